// File: rtl/bs_pkg.sv
// Shared encodings for the Black-Scholes job scheduler: processor cmd/status
// codes, scheduler and slot state encodings, and the chunk sizing helper.
package bs_pkg;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_RUN  = 4'd1;
  localparam logic [3:0] CMD_ACK  = 4'd2;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_RUNNING  = 4'd1;
  localparam logic [3:0] ST_COMPLETE = 4'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } top_state_t;

  typedef enum logic [2:0] {
    SL_FREE   = 3'd0,
    SL_LAUNCH = 3'd1,
    SL_BUSY   = 3'd2,
    SL_DONE   = 3'd3,
    SL_ACK    = 3'd4
  } slot_state_t;

  function automatic logic [31:0] chunk_size(input logic [31:0] rem, input logic [31:0] lim);
    return (rem > lim) ? lim : rem;
  endfunction

endpackage

// File: rtl/bs_rr_arbiter.sv
// Combinational round-robin arbiter: picks the requester closest to ptr
// (counting upward with wrap) and returns it as one-hot grant and index.
module bs_rr_arbiter
  import bs_pkg::*;
#(
  parameter int NUM_PROC = 4,
  parameter int IDW      = 4
) (
  input  logic [NUM_PROC-1:0] req,
  input  logic [IDW-1:0]      ptr,
  output logic [NUM_PROC-1:0] grant,
  output logic [IDW-1:0]      idx,
  output logic                any
);

  always_comb begin
    int best_d;
    int d;
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    best_d = NUM_PROC;
    d      = 0;
    for (int j = 0; j < NUM_PROC; j++) begin
      // distance from the pointer, so the pointer slot itself has top priority
      d = (j + NUM_PROC - int'(ptr)) % NUM_PROC;
      if (req[j] && (d < best_d)) begin
        best_d   = d;
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bs_job_scheduler.sv
// Splits a Monte-Carlo request into chunks, dispatches them over the processor
// array via the cmd/status handshake and streams per-chunk results out.
module bs_job_scheduler
  import bs_pkg::*;
#(
  parameter int NUM_PROC = 4,
  parameter int CHUNK    = 1024,
  parameter int IDW      = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   start,
  input  logic [31:0]            total_iter,
  output logic                   busy,
  output logic                   done,
  output logic [4*NUM_PROC-1:0]  proc_cmd,
  output logic [32*NUM_PROC-1:0] proc_niter,
  input  logic [4*NUM_PROC-1:0]  proc_status,
  input  logic [32*NUM_PROC-1:0] proc_acc,
  input  logic [32*NUM_PROC-1:0] proc_pow,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_acc,
  output logic [31:0]            res_pow,
  output logic [31:0]            res_niter,
  output logic [IDW-1:0]         res_id
);

  localparam logic [31:0] CHUNK_W = 32'(CHUNK);

  top_state_t            state, state_nxt;
  slot_state_t           slot_q [NUM_PROC];
  slot_state_t           slot_d [NUM_PROC];
  logic [31:0]           remaining, remaining_d, chunk;
  logic [4*NUM_PROC-1:0] cmd_d;
  logic [32*NUM_PROC-1:0] niter_d;
  logic [IDW-1:0]        rr_ptr, cap_idx;
  logic [NUM_PROC-1:0]   disp_req, disp_sel, done_req, cap_grant;
  logic                  disp_en, cap_any, cap_en, all_free;
  logic [31:0]           cap_acc, cap_pow, cap_niter;

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_FIN);
  assign chunk = chunk_size(remaining, CHUNK_W);

  always_comb begin
    logic [3:0] st;
    st       = ST_IDLE;
    all_free = 1'b1;
    disp_req = '0;
    done_req = '0;
    disp_sel = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      st          = proc_status[4*i +: 4];
      all_free    = all_free && (slot_q[i] == SL_FREE);
      disp_req[i] = (state == S_RUN) && (slot_q[i] == SL_FREE) && (st == ST_IDLE) && (remaining != '0);
      done_req[i] = (slot_q[i] == SL_DONE);
    end
    // lowest index wins dispatch
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (disp_req[i]) begin
        disp_sel    = '0;
        disp_sel[i] = 1'b1;
      end
    end
    disp_en = |disp_req;
  end

  bs_rr_arbiter #(
    .NUM_PROC (NUM_PROC),
    .IDW      (IDW)
  ) u_res_arb (
    .req   (done_req),
    .ptr   (rr_ptr),
    .grant (cap_grant),
    .idx   (cap_idx),
    .any   (cap_any)
  );

  assign cap_en = cap_any && (!res_valid || res_ready);

  always_comb begin
    cap_acc   = '0;
    cap_pow   = '0;
    cap_niter = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (cap_grant[i]) begin
        cap_acc   = proc_acc[32*i +: 32];
        cap_pow   = proc_pow[32*i +: 32];
        cap_niter = proc_niter[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (total_iter == '0) ? S_FIN : S_RUN;
      S_RUN:   if ((remaining == '0) && all_free && !res_valid) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    logic [3:0] st;
    st          = ST_IDLE;
    remaining_d = remaining;
    cmd_d       = proc_cmd;
    niter_d     = proc_niter;
    if ((state == S_IDLE) && start) remaining_d = total_iter;
    else if (disp_en)               remaining_d = remaining - chunk;
    for (int i = 0; i < NUM_PROC; i++) begin
      st        = proc_status[4*i +: 4];
      slot_d[i] = slot_q[i];
      // statuses not expected in a state leave the slot where it is
      case (slot_q[i])
        SL_FREE: if (disp_sel[i]) begin
          slot_d[i]             = SL_LAUNCH;
          cmd_d[4*i +: 4]       = CMD_RUN;
          niter_d[32*i +: 32]   = chunk;
        end
        SL_LAUNCH: if (st == ST_RUNNING) begin
          slot_d[i]       = SL_BUSY;
          cmd_d[4*i +: 4] = CMD_NONE;
        end
        SL_BUSY: if (st == ST_COMPLETE) slot_d[i] = SL_DONE;
        SL_DONE: if (cap_en && cap_grant[i]) begin
          slot_d[i]       = SL_ACK;
          cmd_d[4*i +: 4] = CMD_ACK;
        end
        SL_ACK: if (st == ST_IDLE) begin
          slot_d[i]       = SL_FREE;
          cmd_d[4*i +: 4] = CMD_NONE;
        end
        default: slot_d[i] = slot_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      remaining  <= '0;
      proc_cmd   <= '0;
      proc_niter <= '0;
      for (int i = 0; i < NUM_PROC; i++) slot_q[i] <= SL_FREE;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_d;
      proc_cmd   <= cmd_d;
      proc_niter <= niter_d;
      for (int i = 0; i < NUM_PROC; i++) slot_q[i] <= slot_d[i];
    end
  end

  // output register refills on the same edge it is drained
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      res_valid <= 1'b0;
      res_acc   <= '0;
      res_pow   <= '0;
      res_niter <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else if (cap_en) begin
      res_valid <= 1'b1;
      res_acc   <= cap_acc;
      res_pow   <= cap_pow;
      res_niter <= cap_niter;
      res_id    <= cap_idx;
      rr_ptr    <= (cap_idx == IDW'(NUM_PROC - 1)) ? '0 : cap_idx + IDW'(1);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
